arb2to1_stream: RTL
===================

// Module: arb2to1_stream
// PURPOSE
//  Two-input round-robin stream arbiter with valid/ready handshakes on both inputs and on the output.
//  Shares one N-bit downstream consumer between requesters A and B.
//  The N-bit data path uses a 2:1 mux; the arbiter FSM drives its select line.
//  The output is registered: one pipeline stage, full throughput.
// PARAMETERS
//  N  1  data width in bits, N >= 1
// PORTS
//  clk        in   1  single clock; all state changes on its rising edge
//  rst_n      in   1  asynchronous active-low reset (assert async, release sync to clk)
//  a_valid    in   1  requester A holds a beat
//  a_ready    out  1  arbiter accepts A this cycle
//  a_data     in   N  requester A payload
//  b_valid    in   1  requester B holds a beat
//  b_ready    out  1  arbiter accepts B this cycle
//  b_data     in   N  requester B payload
//  out_valid  out  1  output register holds a beat
//  out_ready  in   1  consumer accepts output beat
//  out_data   out  N  registered payload
//  out_src    out  1  source of the output beat: 0 = A, 1 = B
// BEHAVIOUR
//  Reset values:
//   - out_valid=0, out_data='0, out_src=0
//   - prio_a=1 (A wins the first contention); FSM in ARB_IDLE
//  accept = !out_valid | out_ready (output slot free or draining this cycle)
//  Ready signals do not depend on the port's own valid:
//   - a_ready = accept & !(b_valid & !prio_a)
//   - b_ready = accept & !(a_valid &  prio_a)
//  Grant:
//   - Both valid: exactly one of a_ready/b_ready can be 1.
//   - One valid: that source is granted whenever accept=1.
//  fire_x = x_valid & x_ready. Mux select sel = fire_b.
//  On any fire:
//   - out_data <= muxed data; out_src <= sel; out_valid <= 1
//   - prio_a <= sel (the source just served loses priority)
//  No fire but out_ready: out_valid <= 0; out_data/out_src hold.
//  Latency: 1 cycle from input fire to out_valid. Throughput: 1 beat/clk under continuous out_ready.
//  Backpressure: out_valid=1 & !out_ready:
//   - a_ready=b_ready=0
//   - out_data and out_src stable until consumed
//  Idle inputs: prio_a unchanged.
//  Reset mid-operation: the buffered beat is discarded and priority returns to A.
// CONFIGURATION
//  Macro ARB2_PKT_LOCK_EN.
//  Defined:
//   - Adds ports a_last (in, 1), b_last (in, 1) and out_last (out, 1, reset 0), registered alongside out_data.
//   - FSM: ARB_IDLE -> ARB_LOCK_A on fire_a & !a_last; ARB_IDLE -> ARB_LOCK_B on fire_b & !b_last.
//   - ARB_LOCK_X -> ARB_IDLE on fire_x & x_last.
//   - In ARB_LOCK_A: a_ready = accept, b_ready = 0 (mirror for ARB_LOCK_B).
//   - prio_a updates only on a beat with last=1 (packet granularity).
//   - A single-beat packet (last=1 on first beat) never leaves ARB_IDLE.
//  Undefined:
//   - No last ports; FSM is fixed in ARB_IDLE.
//   - Arbitration is per beat, exactly as described in BEHAVIOUR.
// STRUCTURE
//  Package arb2_pkg:
//   - typedef enum logic {SRC_A=1'b0, SRC_B=1'b1} src_t
//   - typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK_A, ARB_LOCK_B} arb_state_t
//  Sub-module: instantiate mux2to1_Nbit #(.N(N)) for the data select, with s=sel.
//  Under ARB2_PKT_LOCK_EN, a second mux2to1_Nbit #(.N(1)) selects last.
//  The FSM and output register stay inline.
// TESTING
//  1. Reset: hold rst_n=0 with a_valid=b_valid=1 -> out_valid=0, a_ready=b_ready=0 (out_valid=0, so accept=1 but both ready are gated by reset), out_data=0.
//  2. Contention: out_ready=1, a_valid=b_valid=1 constantly, a_data=8'hAA, b_data=8'h55, N=8
//     -> out_src alternates 0,1,0,1 with A first; out_data alternates AA,55; out_valid=1 every cycle from cycle 1.
//  3. Backpressure: fill output with A beat 8'h11, hold out_ready=0 for 3 cycles
//     -> out_data stays 11, a_ready=b_ready=0; on out_ready=1 the next beat fires the same cycle.
//  4. Single requester: only b_valid=1 for 4 beats -> 4 B beats back-to-back; a later A+B contention grants A.
//  5. Reset mid-transfer: out_valid=1 with data 8'h77; pulse rst_n low between edges
//     -> out_valid drops immediately (async); after release the first contention grants A.
//  6. ARB2_PKT_LOCK_EN: A sends 3-beat packet (last on beat 3) while b_valid=1
//     -> b_ready=0 for all 3 beats; B granted on the next cycle; out_last=1 only with beat 3.

Source files
------------

// File: rtl/arb2_pkg.sv
// Shared types for the two-input round-robin stream arbiter.
package arb2_pkg;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LOCK_A,
    ARB_LOCK_B
  } arb_state_t;

endpackage

// File: rtl/arb2to1_stream_mux.sv
// Plain N-bit 2:1 multiplexer: y = s ? d1 : d0.
module mux2to1_Nbit #(
  parameter int N = 1
) (
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic         s,
  output logic [N-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/arb2to1_stream.sv
// Two-input round-robin valid/ready stream arbiter with a registered output stage.
// Define ARB2_PKT_LOCK_EN for packet-granular arbitration using a_last/b_last/out_last.
module arb2to1_stream
  import arb2_pkg::*;
#(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [N-1:0] a_data,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [N-1:0] b_data,
`ifdef ARB2_PKT_LOCK_EN
  input  logic         a_last,
  input  logic         b_last,
  output logic         out_last,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_src
);

  arb_state_t   state_q, state_d;
  logic         prio_a_q, prio_a_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_data_q, out_data_d;
  src_t         out_src_q, out_src_d;

  logic         accept;
  logic         a_ready_c, b_ready_c;
  logic         fire_a, fire_b, sel;
  logic [N-1:0] mux_data;

  mux2to1_Nbit #(.N(N)) u_data_mux (
    .d0 (a_data),
    .d1 (b_data),
    .s  (sel),
    .y  (mux_data)
  );

`ifdef ARB2_PKT_LOCK_EN
  logic out_last_q, out_last_d;
  logic mux_last;

  mux2to1_Nbit #(.N(1)) u_last_mux (
    .d0 (a_last),
    .d1 (b_last),
    .s  (sel),
    .y  (mux_last)
  );
`endif

  // Ready/grant: depends only on the other port's valid, the priority bit and lock state.
  // Held low while reset is asserted so nothing is accepted into a slot being cleared.
  always_comb begin
    accept    = !out_valid_q | out_ready;
    a_ready_c = 1'b0;
    b_ready_c = 1'b0;
    case (state_q)
      ARB_LOCK_A: a_ready_c = accept;
      ARB_LOCK_B: b_ready_c = accept;
      default: begin
        a_ready_c = accept & !(b_valid & !prio_a_q);
        b_ready_c = accept & !(a_valid &  prio_a_q);
      end
    endcase
    a_ready_c = a_ready_c & rst_n;
    b_ready_c = b_ready_c & rst_n;
    fire_a    = a_valid & a_ready_c;
    fire_b    = b_valid & b_ready_c;
    sel       = fire_b;
  end

  always_comb begin
    state_d     = state_q;
    prio_a_d    = prio_a_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
`ifdef ARB2_PKT_LOCK_EN
    out_last_d  = out_last_q;
`endif
    if (fire_a | fire_b) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_src_d   = src_t'(sel);
`ifdef ARB2_PKT_LOCK_EN
      out_last_d  = mux_last;
      // Priority rotates only at packet boundaries; a packet locks its source until last.
      if (mux_last) prio_a_d = sel;
      case (state_q)
        ARB_IDLE: begin
          if (fire_a && !a_last) state_d = ARB_LOCK_A;
          else if (fire_b && !b_last) state_d = ARB_LOCK_B;
        end
        ARB_LOCK_A: if (fire_a && a_last) state_d = ARB_IDLE;
        ARB_LOCK_B: if (fire_b && b_last) state_d = ARB_IDLE;
        default:    state_d = ARB_IDLE;
      endcase
`else
      prio_a_d    = sel;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
`ifndef ARB2_PKT_LOCK_EN
    state_d = ARB_IDLE;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      prio_a_q    <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= SRC_A;
`ifdef ARB2_PKT_LOCK_EN
      out_last_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      prio_a_q    <= prio_a_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
`ifdef ARB2_PKT_LOCK_EN
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign a_ready   = a_ready_c;
  assign b_ready   = b_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
`ifdef ARB2_PKT_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule
